// File: rtl/cond_issue_ctrl_if.sv
// rtl/cond_issue_ctrl_if.sv - instruction, ALU, flag and counter signals of cond_issue_ctrl
interface cond_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic        in_s;
  logic [7:0]  in_tag;
  logic        alu_valid;
  logic        alu_ready;
  logic [7:0]  alu_tag;
  logic        alu_done;
  logic [3:0]  alu_nzcv;
  logic        flag_we;
  logic [3:0]  flag_wdata;
  logic [3:0]  nzcv;
  logic        skip;
  logic [7:0]  skip_tag;
  logic        cnt_clr;
  logic [15:0] issue_cnt;
  logic [15:0] skip_cnt;

  modport master (
    output in_valid, in_cond, in_s, in_tag, alu_ready, alu_done, alu_nzcv,
           flag_we, flag_wdata, cnt_clr,
    input  in_ready, alu_valid, alu_tag, nzcv, skip, skip_tag, issue_cnt, skip_cnt
  );

  modport slave (
    input  in_valid, in_cond, in_s, in_tag, alu_ready, alu_done, alu_nzcv,
           flag_we, flag_wdata, cnt_clr,
    output in_ready, alu_valid, alu_tag, nzcv, skip, skip_tag, issue_cnt, skip_cnt
  );
endinterface

// File: rtl/cond_issue_ctrl.sv
// rtl/cond_issue_ctrl.sv - ARMv4 condition evaluation, ALU issue and flag register control
module cond_issue_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  cond_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECIDE, ISSUE, WAIT} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_alu_valid;
  logic [3:0]  r_cond;
  logic        r_s;
  logic [7:0]  r_tag;
  logic [3:0]  r_nzcv;
  logic [15:0] r_issue_cnt;
  logic [15:0] r_skip_cnt;

  logic        w_pass;
  logic        w_skip;
  logic        w_fire;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // The squash pulse is decoded from registered state so it lands in the DECIDE cycle itself.
  assign w_pass = cond_pass(r_cond, r_nzcv);
  assign w_skip = (r_state == DECIDE) && !w_pass;
  assign w_fire = r_alu_valid && bus.alu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_alu_valid <= 1'b0;
      r_cond      <= 4'b0;
      r_s         <= 1'b0;
      r_tag       <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_cond     <= bus.in_cond;
            r_s        <= bus.in_s;
            r_tag      <= bus.in_tag;
            r_in_ready <= 1'b0;
            r_state    <= DECIDE;
          end
        end
        DECIDE: begin
          if (w_pass) begin
            r_alu_valid <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.alu_ready) begin
            r_alu_valid <= 1'b0;
            if (r_s) begin
              r_state <= WAIT;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        WAIT: begin
          if (bus.alu_done) begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ALU result outranks a coincident direct write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv <= 4'b0000;
    end else if ((r_state == WAIT) && bus.alu_done) begin
      r_nzcv <= bus.alu_nzcv;
    end else if (bus.flag_we) begin
      r_nzcv <= bus.flag_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= 16'h0000;
      r_skip_cnt  <= 16'h0000;
    end else if (bus.cnt_clr) begin
      r_issue_cnt <= 16'h0000;
      r_skip_cnt  <= 16'h0000;
    end else begin
      if (w_fire && (r_issue_cnt != 16'hFFFF)) r_issue_cnt <= r_issue_cnt + 16'h0001;
      if (w_skip && (r_skip_cnt != 16'hFFFF))  r_skip_cnt  <= r_skip_cnt + 16'h0001;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.alu_valid = r_alu_valid;
  assign bus.alu_tag   = r_tag;
  assign bus.skip      = w_skip;
  assign bus.skip_tag  = r_tag;
  assign bus.nzcv      = r_nzcv;
  assign bus.issue_cnt = r_issue_cnt;
  assign bus.skip_cnt  = r_skip_cnt;
endmodule

// File: tb/tb_cond_issue_ctrl.sv
// tb/tb_cond_issue_ctrl.sv - directed scoreboard bench for cond_issue_ctrl
module tb_cond_issue_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic       is_skip;
    logic [7:0] tag;
  } exp_t;

  exp_t sb[$];

  cond_issue_ctrl_if ifc ();

  cond_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic s, input logic [7:0] t, input logic exp_skip);
    int n;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", ifc.in_ready, 1);
    ifc.in_valid = 1'b1;
    ifc.in_cond  = c;
    ifc.in_s     = s;
    ifc.in_tag   = t;
    sb.push_back('{is_skip: exp_skip, tag: t});
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic observe(input string nm);
    int   n;
    exp_t e;
    n = 0;
    while (!(ifc.skip || (ifc.alu_valid && ifc.alu_ready)) && n < 50) begin
      step();
      n++;
    end
    chk({nm, "_event"}, ifc.skip || (ifc.alu_valid && ifc.alu_ready), 1);
    chk({nm, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({nm, "_kind"}, ifc.skip, e.is_skip);
      chk({nm, "_tag"}, ifc.skip ? ifc.skip_tag : ifc.alu_tag, e.tag);
    end
    step();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_cond    = 4'h0;
    ifc.in_s       = 1'b0;
    ifc.in_tag     = 8'h00;
    ifc.alu_ready  = 1'b1;
    ifc.alu_done   = 1'b0;
    ifc.alu_nzcv   = 4'h0;
    ifc.flag_we    = 1'b0;
    ifc.flag_wdata = 4'h0;
    ifc.cnt_clr    = 1'b0;

    step();
    step();
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_nzcv", ifc.nzcv, 0);
    chk("rst_alu_valid", ifc.alu_valid, 0);
    chk("rst_skip", ifc.skip, 0);
    chk("rst_alu_tag", ifc.alu_tag, 0);
    chk("rst_skip_tag", ifc.skip_tag, 0);
    chk("rst_issue_cnt", ifc.issue_cnt, 0);
    chk("rst_skip_cnt", ifc.skip_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", ifc.in_ready, 1);

    // squash
    send(4'b0000, 1'b0, 8'h33, 1'b1);
    chk("squash_no_valid", ifc.alu_valid, 0);
    observe("squash");
    chk("squash_one_cycle", ifc.skip, 0);
    chk("squash_no_valid2", ifc.alu_valid, 0);
    chk("squash_cnt", ifc.skip_cnt, 1);

    // flag interlock: MOVS then BEQ
    send(4'b1110, 1'b1, 8'h01, 1'b0);
    observe("movs");
    ifc.in_valid = 1'b1;
    ifc.in_cond  = 4'b0000;
    ifc.in_s     = 1'b0;
    ifc.in_tag   = 8'h02;
    for (int i = 0; i < 3; i++) begin
      chk("wait_in_ready", ifc.in_ready, 0);
      chk("wait_no_valid", ifc.alu_valid, 0);
      step();
    end
    ifc.in_valid = 1'b0;
    ifc.alu_done = 1'b1;
    ifc.alu_nzcv = 4'b0100;
    step();
    ifc.alu_done = 1'b0;
    chk("movs_nzcv", ifc.nzcv, 4'b0100);
    send(4'b0000, 1'b0, 8'h02, 1'b0);
    observe("beq");
    chk("interlock_issue_cnt", ifc.issue_cnt, 2);

    // backpressure
    ifc.alu_ready = 1'b0;
    send(4'b1110, 1'b0, 8'h44, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", ifc.alu_valid, 1);
      chk("bp_tag", ifc.alu_tag, 8'h44);
      chk("bp_in_ready", ifc.in_ready, 0);
      step();
    end
    chk("bp_cnt_held", ifc.issue_cnt, 2);
    ifc.alu_ready = 1'b1;
    observe("bp");
    chk("bp_cnt", ifc.issue_cnt, 3);

    // alu_done vs flag_we collision in WAIT
    send(4'b1110, 1'b1, 8'h55, 1'b0);
    observe("coll");
    ifc.alu_done   = 1'b1;
    ifc.alu_nzcv   = 4'b1001;
    ifc.flag_we    = 1'b1;
    ifc.flag_wdata = 4'b0110;
    step();
    ifc.alu_done = 1'b0;
    ifc.flag_we  = 1'b0;
    chk("coll_nzcv", ifc.nzcv, 4'b1001);

    // stray alu_done in IDLE, then direct write
    ifc.alu_done = 1'b1;
    ifc.alu_nzcv = 4'b1111;
    step();
    ifc.alu_done = 1'b0;
    chk("stray_done_idle", ifc.nzcv, 4'b1001);
    ifc.flag_we    = 1'b1;
    ifc.flag_wdata = 4'b0011;
    step();
    ifc.flag_we = 1'b0;
    chk("flag_we_nzcv", ifc.nzcv, 4'b0011);

    // conditions against N=0 Z=0 C=1 V=1
    send(4'b1000, 1'b0, 8'h61, 1'b0);
    observe("hi");
    send(4'b1011, 1'b0, 8'h62, 1'b0);
    observe("lt");
    send(4'b1010, 1'b0, 8'h63, 1'b1);
    observe("ge");
    send(4'b1111, 1'b0, 8'h64, 1'b1);
    observe("nv");

    // DECIDE sees nzcv from before a same-cycle direct write
    send(4'b0000, 1'b0, 8'h65, 1'b1);
    ifc.flag_we    = 1'b1;
    ifc.flag_wdata = 4'b0100;
    observe("old_flags");
    ifc.flag_we = 1'b0;
    chk("old_flags_nzcv", ifc.nzcv, 4'b0100);
    chk("mid_issue_cnt", ifc.issue_cnt, 6);
    chk("mid_skip_cnt", ifc.skip_cnt, 4);

    // saturation
    force dut.r_skip_cnt = 16'hFFFD;
    #1;
    release dut.r_skip_cnt;
    send(4'b1111, 1'b0, 8'h70, 1'b1);
    observe("sat0");
    chk("sat_fffe", ifc.skip_cnt, 16'hFFFE);
    send(4'b1111, 1'b0, 8'h71, 1'b1);
    observe("sat1");
    chk("sat_ffff", ifc.skip_cnt, 16'hFFFF);
    send(4'b1111, 1'b0, 8'h72, 1'b1);
    observe("sat2");
    chk("sat_hold", ifc.skip_cnt, 16'hFFFF);
    send(4'b1111, 1'b0, 8'h73, 1'b1);
    ifc.cnt_clr = 1'b1;
    observe("clr");
    ifc.cnt_clr = 1'b0;
    chk("clr_skip_cnt", ifc.skip_cnt, 0);
    chk("clr_issue_cnt", ifc.issue_cnt, 0);

    // async reset mid-WAIT
    send(4'b1110, 1'b1, 8'h66, 1'b0);
    observe("pre_rst");
    chk("pre_rst_issue_cnt", ifc.issue_cnt, 1);
    chk("pre_rst_nzcv", ifc.nzcv, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", ifc.in_ready, 0);
    chk("arst_alu_valid", ifc.alu_valid, 0);
    chk("arst_nzcv", ifc.nzcv, 0);
    chk("arst_skip", ifc.skip, 0);
    chk("arst_issue_cnt", ifc.issue_cnt, 0);
    chk("arst_skip_cnt", ifc.skip_cnt, 0);
    chk("arst_alu_tag", ifc.alu_tag, 0);
    chk("arst_skip_tag", ifc.skip_tag, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    ifc.alu_done = 1'b1;
    ifc.alu_nzcv = 4'b1111;
    step();
    ifc.alu_done = 1'b0;
    chk("post_arst_nzcv", ifc.nzcv, 0);
    chk("post_arst_in_ready", ifc.in_ready, 1);
    chk("post_arst_valid", ifc.alu_valid, 0);
    chk("post_arst_issue_cnt", ifc.issue_cnt, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cond_issue_ctrl.md
COND_ISSUE_CTRL -- requirements
Module: cond_issue_ctrl

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-low reset; the clock and reset port names SHALL match the rest of the core.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  controller accepts an instruction this cycle.
REQ-006 in_cond  in  4  ARMv4 condition field.
REQ-007 in_s  in  1  instruction sets flags.
REQ-008 in_tag  in  8  instruction identifier.
REQ-009 alu_valid  out  1  issue request to the ALU.
REQ-010 alu_ready  in  1  ALU accepts the issue.
REQ-011 alu_tag  out  8  tag of the issued instruction.
REQ-012 alu_done  in  1  ALU flag result valid.
REQ-013 alu_nzcv  in  4  ALU result flags {N,Z,C,V}.
REQ-014 flag_we  in  1  direct flag write (MSR path).
REQ-015 flag_wdata  in  4  direct flag value.
REQ-016 nzcv  out  4  architectural flag register: bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-017 skip  out  1  one-cycle pulse: instruction squashed by its condition.
REQ-018 skip_tag  out  8  tag of the squashed instruction, valid with skip.
REQ-019 cnt_clr  in  1  synchronous clear of both counters.
REQ-020 issue_cnt  out  16  count of issued instructions.
REQ-021 skip_cnt  out  16  count of squashed instructions.

Function
REQ-022 FSM states SHALL be IDLE, DECIDE, ISSUE and WAIT.
REQ-023 IDLE: in_ready=1; on in_valid, latch in_cond/in_s/in_tag and go to DECIDE; otherwise stay.
REQ-024 in_ready SHALL be 0 in every state except IDLE.
REQ-025 DECIDE: evaluate the latched cond against the current nzcv register; pass -> ISSUE; fail -> skip=1, skip_tag=latched tag, go to IDLE.
REQ-026 Cond pass rules: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 always; 1111 never.
REQ-027 ISSUE: alu_valid=1 and alu_tag=latched tag, both held stable until alu_ready; on alu_ready, latched s=1 -> WAIT, s=0 -> IDLE.
REQ-028 WAIT: hold; on alu_done, nzcv <= alu_nzcv and go to IDLE.
REQ-029 alu_done outside WAIT SHALL be ignored.
REQ-030 flag_we SHALL write nzcv in any state; if alu_done is accepted in WAIT in the same cycle, alu_done SHALL win.
REQ-031 The DECIDE evaluation SHALL use the nzcv value before any same-cycle write.
REQ-032 Minimum latency: accept at cycle T, DECIDE at T+1, alu_valid at T+2; skip pulse at T+1.
REQ-033 issue_cnt SHALL increment on the alu_valid&alu_ready cycle.
REQ-034 skip_cnt SHALL increment on the skip cycle.
REQ-035 Both counters SHALL saturate at 0xFFFF.
REQ-036 If cnt_clr coincides with an increment, cnt_clr SHALL win and the counter SHALL read 0.

Reset
REQ-037 On rst_n=0, all outputs and state SHALL reset immediately: state IDLE, nzcv=0000, alu_valid=0, skip=0, alu_tag=0, skip_tag=0, both counters 0.
REQ-038 During reset in_ready SHALL be 0; after release it SHALL be 1 (IDLE).
REQ-039 Reset asserted in ISSUE or WAIT SHALL abandon the instruction with no counter or flag update.

Verification
REQ-040 Flag interlock: nzcv=0000; send MOVS tag 0x01 (cond 1110, s=1); ALU returns nzcv=0100; then BEQ tag 0x02 (cond 0000) -> tag 0x02 not accepted until WAIT exits, then issued; issue_cnt=2.
REQ-041 Squash: nzcv=0000, cond 0000 tag 0x33 -> skip=1 for exactly one cycle with skip_tag=0x33; alu_valid stays 0; skip_cnt=1.
REQ-042 Backpressure: hold alu_ready=0 for 5 cycles in ISSUE -> alu_valid and alu_tag stable for all 5 cycles, in_ready=0, issue_cnt increments once.
REQ-043 Collision: in WAIT, alu_done with alu_nzcv=1001 and flag_we with flag_wdata=0110 in the same cycle -> nzcv=1001.
REQ-044 Saturation: preload to 0xFFFE via 2 more skips than issued path; two further skips -> skip_cnt=0xFFFF; cnt_clr together with a skip -> skip_cnt=0.
REQ-045 Async reset asserted mid-WAIT -> outputs reset without a clock edge; later stray alu_done ignored; nzcv stays 0000.
